// File: rtl/post_adder_acc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// post_adder_acc : DSP48A1-style post-adder/subtractor and P accumulator
// Rev 1.0
// ----------------------------------------------------------------------------
module post_adder_acc #(
  parameter int    MREG        = 1,
  parameter int    CREG        = 1,
  parameter int    OPMODEREG   = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYOUTREG = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_m,
  input  logic        ce_c,
  input  logic        ce_opmode,
  input  logic        ce_carryin,
  input  logic        ce_p,
  input  logic [35:0] m,
  input  logic [47:0] c,
  input  logic [47:0] dab,
  input  logic [47:0] pcin,
  input  logic        carryin,
  input  logic [7:0]  opmode,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic        carryout,
  output logic        carryoutf
);

  localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

  logic [35:0] m_r;
  logic [47:0] c_r;
  logic [7:0]  opmode_r;
  logic        cin_d;
  logic        cin_r;
  logic [47:0] x_mux;
  logic [47:0] z_mux;
  logic [48:0] res;
  logic [47:0] p_d;
  logic [47:0] p_q;
  logic        carryout_d;

  // Carry-in is chosen from the un-registered opmode so it stays aligned with opmode_r.
  assign cin_d = CIN_FROM_PORT ? carryin : opmode[5];

  generate
    if (MREG != 0) begin : g_mreg
      logic [35:0] m_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       m_q <= '0;
        else if (ce_m) m_q <= m;
      end
      assign m_r = m_q;
    end else begin : g_mwire
      assign m_r = m;
    end

    if (CREG != 0) begin : g_creg
      logic [47:0] c_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       c_q <= '0;
        else if (ce_c) c_q <= c;
      end
      assign c_r = c_q;
    end else begin : g_cwire
      assign c_r = c;
    end

    if (OPMODEREG != 0) begin : g_opreg
      logic [7:0] opmode_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)            opmode_q <= '0;
        else if (ce_opmode) opmode_q <= opmode;
      end
      assign opmode_r = opmode_q;
    end else begin : g_opwire
      assign opmode_r = opmode;
    end

    if (CARRYINREG != 0) begin : g_cinreg
      logic cin_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)             cin_q <= 1'b0;
        else if (ce_carryin) cin_q <= cin_d;
      end
      assign cin_r = cin_q;
    end else begin : g_cinwire
      assign cin_r = cin_d;
    end
  endgenerate

  always_comb begin
    x_mux = '0;
    z_mux = '0;
    case (opmode_r[1:0])
      2'd0:    x_mux = '0;
      2'd1:    x_mux = {12'd0, m_r};
      2'd2:    x_mux = p_q;
      default: x_mux = dab;
    endcase
    case (opmode_r[3:2])
      2'd0:    z_mux = '0;
      2'd1:    z_mux = pcin;
      2'd2:    z_mux = p_q;
      default: z_mux = c_r;
    endcase
    // Subtract borrow shows up as res[48]=1 from the 49-bit modular difference.
    if (opmode_r[7]) res = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin_r});
    else             res = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin_r};
  end

  assign p_d        = res[47:0];
  assign carryout_d = res[48];

  // The P register always exists so feedback never comes from the combinational result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       p_q <= '0;
    else if (ce_p) p_q <= p_d;
  end

  generate
    if (CARRYOUTREG != 0) begin : g_coreg
      logic carryout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       carryout_q <= 1'b0;
        else if (ce_p) carryout_q <= carryout_d;
      end
      assign carryout = carryout_q;
    end else begin : g_cowire
      assign carryout = carryout_d;
    end
  endgenerate

  assign p         = (PREG != 0) ? p_q : p_d;
  assign pcout     = p;
  assign carryoutf = carryout;

  logic unused_bits;
  assign unused_bits = &{1'b0, opmode_r[6], opmode_r[4], opmode[5], carryin};

endmodule
`default_nettype wire

// File: tb/tb_post_adder_acc.sv
`default_nettype none
// Bench for post_adder_acc: vector table, hand-written pipeline sequences and a
// randomized run against an arithmetic reference model.
module tb_post_adder_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_m, ce_c, ce_opmode, ce_carryin, ce_p;
  logic [35:0] m;
  logic [47:0] c, dab, pcin;
  logic        carryin;
  logic [7:0]  opmode;
  logic [47:0] p_a, pcout_a, p_b, pcout_b;
  logic        co_a, cof_a, co_b, cof_b;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  post_adder_acc dut_a (
    .clk(clk), .rst(rst), .ce_m(ce_m), .ce_c(ce_c), .ce_opmode(ce_opmode),
    .ce_carryin(ce_carryin), .ce_p(ce_p), .m(m), .c(c), .dab(dab), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .p(p_a), .pcout(pcout_a),
    .carryout(co_a), .carryoutf(cof_a)
  );

  post_adder_acc #(.CARRYINSEL("CARRYIN")) dut_b (
    .clk(clk), .rst(rst), .ce_m(ce_m), .ce_c(ce_c), .ce_opmode(ce_opmode),
    .ce_carryin(ce_carryin), .ce_p(ce_p), .m(m), .c(c), .dab(dab), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .p(p_b), .pcout(pcout_b),
    .carryout(co_b), .carryoutf(cof_b)
  );

  typedef struct {
    logic [35:0] m;
    logic [47:0] c;
    logic [47:0] dab;
    logic [47:0] pcin;
    logic        cin;
    logic [7:0]  op;
    logic [47:0] pa;
    logic        coa;
    logic [47:0] pb;
    logic        cob;
  } vec_t;

  vec_t vecs[10];

  // Reference model state: values captured by the input stage, and the P/carry state.
  logic [35:0] sm;
  logic [47:0] sc;
  logic [7:0]  sop;
  logic        scin_a, scin_b;
  logic [47:0] mp_a, mp_b;
  logic        mco_a, mco_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_a(input string tag, input logic [47:0] ep, input logic eco);
    chk({tag, " p_a"}, 64'(p_a), 64'(ep));
    chk({tag, " pcout_a"}, 64'(pcout_a), 64'(ep));
    chk({tag, " carryout_a"}, 64'(co_a), 64'(eco));
    chk({tag, " carryoutf_a"}, 64'(cof_a), 64'(eco));
  endtask

  task automatic chk_b(input string tag, input logic [47:0] ep, input logic eco);
    chk({tag, " p_b"}, 64'(p_b), 64'(ep));
    chk({tag, " pcout_b"}, 64'(pcout_b), 64'(ep));
    chk({tag, " carryout_b"}, 64'(co_b), 64'(eco));
    chk({tag, " carryoutf_b"}, 64'(cof_b), 64'(eco));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic all_ce(input logic v);
    ce_m = v; ce_c = v; ce_opmode = v; ce_carryin = v; ce_p = v;
  endtask

  // 49-bit result from plain integer arithmetic on the selected operands.
  function automatic logic [48:0] alu(input logic [7:0] op, input logic [35:0] mv,
                                      input logic [47:0] cv, input logic [47:0] pfb,
                                      input logic [47:0] pcv, input logic [47:0] dv,
                                      input logic ci);
    longint unsigned x, z, r;
    case (op[1:0])
      2'd0:    x = 0;
      2'd1:    x = 64'(mv);
      2'd2:    x = 64'(pfb);
      default: x = 64'(dv);
    endcase
    case (op[3:2])
      2'd0:    z = 0;
      2'd1:    z = 64'(pcv);
      2'd2:    z = 64'(pfb);
      default: z = 64'(cv);
    endcase
    r = op[7] ? (z - x - 64'(ci)) : (z + x + 64'(ci));
    return r[48:0];
  endfunction

  task automatic model_reset();
    sm = '0; sc = '0; sop = '0; scin_a = 1'b0; scin_b = 1'b0;
    mp_a = '0; mp_b = '0; mco_a = 1'b0; mco_b = 1'b0;
  endtask

  task automatic model_step();
    logic [48:0] ra, rb;
    ra = alu(sop, sm, sc, mp_a, pcin, dab, scin_a);
    rb = alu(sop, sm, sc, mp_b, pcin, dab, scin_b);
    if (ce_p) begin
      mp_a = ra[47:0]; mco_a = ra[48];
      mp_b = rb[47:0]; mco_b = rb[48];
    end
    if (ce_m)       sm = m;
    if (ce_c)       sc = c;
    if (ce_opmode)  sop = opmode;
    if (ce_carryin) begin
      scin_a = opmode[5];
      scin_b = carryin;
    end
  endtask

  initial begin
    //           m              c                   dab                 pcin                cin  op     pa                  coa   pb                  cob
    vecs[0] = '{36'd5,          48'd10,             48'd0,              48'd0,              1'b0, 8'h0D, 48'd15,             1'b0, 48'd15,             1'b0};
    vecs[1] = '{36'd5,          48'd3,              48'd0,              48'd0,              1'b0, 8'h8D, 48'hFFFF_FFFF_FFFE, 1'b1, 48'hFFFF_FFFF_FFFE, 1'b1};
    vecs[2] = '{36'd0,          48'hFFFF_FFFF_FFFF, 48'd0,              48'd0,              1'b0, 8'h2C, 48'd0,              1'b1, 48'hFFFF_FFFF_FFFF, 1'b0};
    vecs[3] = '{36'd0,          48'd0,              48'd1,              48'd0,              1'b1, 8'h03, 48'd1,              1'b0, 48'd2,              1'b0};
    vecs[4] = '{36'd0,          48'd0,              48'd23,             48'd100,            1'b0, 8'h07, 48'd123,            1'b0, 48'd123,            1'b0};
    vecs[5] = '{36'd1,          48'd0,              48'd0,              48'd1000,           1'b0, 8'h85, 48'd999,            1'b0, 48'd999,            1'b0};
    vecs[6] = '{36'hF_FFFF_FFFF, 48'd1,             48'd0,              48'd0,              1'b0, 8'h0D, 48'h10_0000_0000,   1'b0, 48'h10_0000_0000,   1'b0};
    vecs[7] = '{36'd3,          48'd10,             48'd0,              48'd0,              1'b0, 8'hAD, 48'd6,              1'b0, 48'd7,              1'b0};
    vecs[8] = '{36'd0,          48'd0,              48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 8'h07, 48'd0,              1'b1, 48'd0,              1'b1};
    vecs[9] = '{36'd0,          48'd0,              48'd0,              48'd0,              1'b0, 8'hA0, 48'hFFFF_FFFF_FFFF, 1'b1, 48'd0,              1'b0};

    // Reset with nonzero inputs.
    rst = 1'b1; all_ce(1'b1);
    m = 36'd123; c = 48'd456; dab = 48'd7; pcin = 48'd9; carryin = 1'b1; opmode = 8'h2D;
    tick(); tick();
    chk_a("reset", 48'd0, 1'b0);
    chk_b("reset", 48'd0, 1'b0);

    // First result two edges after release.
    rst = 1'b0; m = 36'd5; c = 48'd10; opmode = 8'h0D; carryin = 1'b0;
    tick();
    chk_a("post-reset edge1", 48'd0, 1'b0);
    tick();
    chk_a("post-reset edge2", 48'd15, 1'b0);

    // Table vectors, inputs held for two edges.
    for (int i = 0; i < 10; i++) begin
      m = vecs[i].m; c = vecs[i].c; dab = vecs[i].dab; pcin = vecs[i].pcin;
      carryin = vecs[i].cin; opmode = vecs[i].op;
      tick(); tick();
      chk_a($sformatf("vec%0d", i), vecs[i].pa, vecs[i].coa);
      chk_b($sformatf("vec%0d", i), vecs[i].pb, vecs[i].cob);
    end

    // Accumulation from a cleared P.
    dab = '0; pcin = '0; carryin = 1'b0; c = '0;
    rst = 1'b1; m = 36'd100; opmode = 8'h09;
    #1 chk_a("acc reset", 48'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_a("acc start", 48'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_a($sformatf("acc step%0d", i), 48'(100 * i), 1'b0);
    end
    // P frozen while M keeps loading.
    ce_p = 1'b0; m = 36'd7;
    tick();
    chk_a("hold1", 48'd400, 1'b0);
    tick();
    chk_a("hold2", 48'd400, 1'b0);
    ce_p = 1'b1;
    tick();
    chk_a("resume", 48'd407, 1'b0);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1 chk_a("async rst", 48'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_a("after rst edge1", 48'd0, 1'b0);
    tick();
    chk_a("after rst edge2", 48'd7, 1'b0);
    tick();
    chk_a("after rst edge3", 48'd14, 1'b0);

    // Randomized run against the reference model.
    for (int i = 0; i < 300; i++) begin
      rst        = (i == 0) || ($urandom_range(19) == 0);
      ce_m       = ($urandom_range(3) != 0);
      ce_c       = ($urandom_range(3) != 0);
      ce_opmode  = ($urandom_range(3) != 0);
      ce_carryin = ($urandom_range(3) != 0);
      ce_p       = ($urandom_range(3) != 0);
      m          = 36'({$urandom(), $urandom()});
      c          = 48'({$urandom(), $urandom()});
      dab        = 48'({$urandom(), $urandom()});
      pcin       = 48'({$urandom(), $urandom()});
      carryin    = 1'($urandom());
      opmode     = 8'($urandom());
      #1;
      if (rst) model_reset();
      chk_a($sformatf("rand%0d", i), mp_a, mco_a);
      chk_b($sformatf("rand%0d", i), mp_b, mco_b);
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
